// File: rtl/reg_writeback_pkg.sv
// Shared widths, write-mode codes, load FIFO entry layout and load helpers.
package reg_writeback_pkg;

    localparam int unsigned WIDTH        = 32;
    localparam int unsigned REG_ADDR_LEN = 5;
    localparam int unsigned MODE_W       = 2;

    localparam logic [MODE_W-1:0] W_MODE_WORD = 2'd0;
    localparam logic [MODE_W-1:0] W_MODE_HALF = 2'd1;
    localparam logic [MODE_W-1:0] W_MODE_BYTE = 2'd2;

    // One queued load write: destination, lane-aligned data, write mode.
    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] rd;
        logic [WIDTH-1:0]        data;
        logic [MODE_W-1:0]       mode;
    } wb_entry_t;

    // Word needs offset 0, halfword needs an even offset, code 3 is never legal.
    function automatic logic is_misaligned(input logic [MODE_W-1:0] mode,
                                           input logic [1:0]        addr_lo);
        logic bad;
        case (mode)
            W_MODE_WORD: bad = (addr_lo != 2'd0);
            W_MODE_HALF: bad = addr_lo[0];
            W_MODE_BYTE: bad = 1'b0;
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Shift the addressed lane down to bit 0; the register file zero-extends.
    function automatic logic [WIDTH-1:0] lane_extract(input logic [WIDTH-1:0]  data,
                                                      input logic [MODE_W-1:0] mode,
                                                      input logic [1:0]        addr_lo);
        logic [WIDTH-1:0] res;
        case (mode)
            W_MODE_BYTE: res = data >> {addr_lo, 3'b000};
            W_MODE_HALF: res = data >> {addr_lo[1], 4'b0000};
            default:     res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Small load-return FIFO with registered full flag, occupancy and per-entry
// valid/rd taps so the top level can answer hazard queries.
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_push,
    input  wb_entry_t                           i_push_entry,
    input  logic                                i_pop,
    output wb_entry_t                           o_head,
    output logic                                o_full,
    output logic [$clog2(DEPTH):0]              o_count,
    output logic [DEPTH-1:0]                    o_valid,
    output logic [DEPTH-1:0][REG_ADDR_LEN-1:0]  o_rd
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic [DEPTH-1:0]   r_valid;

    logic               w_push_ok;
    logic               w_pop_ok;
    logic [CNT_W-1:0]   w_count_next;
    logic [DEPTH-1:0]   w_valid_next;

    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && (r_count != '0);

    // Next occupancy and entry-valid map; push and pop never hit the same slot.
    always_comb begin
        w_count_next = r_count;
        w_valid_next = r_valid;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - CNT_W'(1);
        end
        if (w_pop_ok) begin
            w_valid_next[r_rd_ptr] = 1'b0;
        end
        if (w_push_ok) begin
            w_valid_next[r_wr_ptr] = 1'b1;
        end
    end

    // Pointers, occupancy and full flag; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_valid  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_valid <= w_valid_next;
        end
    end

    // Entry storage; contents are qualified by r_valid so need no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_count = r_count;
    assign o_valid = r_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd_tap
        assign o_rd[g] = r_mem[g].rd;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write initiator: merges ALU results and buffered load returns
// into one registered write port, with starvation stall and hazard query.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [REG_ADDR_LEN-1:0]  alu_rd,
    input  logic [WIDTH-1:0]         alu_data,
    output logic                     alu_stall,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [REG_ADDR_LEN-1:0]  mem_rd,
    input  logic [WIDTH-1:0]         mem_data,
    input  logic [MODE_W-1:0]        mem_mode,
    input  logic [1:0]               mem_addr_lo,
    output logic                     misalign,
    input  logic [REG_ADDR_LEN-1:0]  rs_a,
    input  logic [REG_ADDR_LEN-1:0]  rs_b,
    output logic                     hazard_a,
    output logic                     hazard_b,
    output logic [REG_ADDR_LEN-1:0]  rc,
    output logic [WIDTH-1:0]         dataC,
    output logic                     w_en,
    output logic [MODE_W-1:0]        w_mode
);

    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);

    wb_entry_t                          w_push_entry;
    wb_entry_t                          w_head;
    logic                               w_full;
    logic [CNT_W-1:0]                   w_count;
    logic [DEPTH-1:0]                   w_fifo_valid;
    logic [DEPTH-1:0][REG_ADDR_LEN-1:0] w_fifo_rd;
    logic                               w_empty;
    logic                               w_mis;
    logic                               w_accept;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_match_a;
    logic                               w_match_b;

    logic                               r_w_en;
    logic [REG_ADDR_LEN-1:0]            r_rc;
    logic [WIDTH-1:0]                   r_dataC;
    logic [MODE_W-1:0]                  r_w_mode;
    logic                               r_misalign;
    logic                               r_alu_stall;
    logic [STARVE_W-1:0]                r_starve;

    assign w_empty  = (w_count == '0);
    assign w_mis    = is_misaligned(mem_mode, mem_addr_lo);
    assign w_accept = mem_valid && !w_full;
    assign w_push   = w_accept && !w_mis && (mem_rd != '0);
    assign w_pop    = !alu_valid && !w_empty;

    assign w_push_entry.rd   = mem_rd;
    assign w_push_entry.data = lane_extract(mem_data, mem_mode, mem_addr_lo);
    assign w_push_entry.mode = mem_mode;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_count      (w_count),
        .o_valid      (w_fifo_valid),
        .o_rd         (w_fifo_rd)
    );

    // Write port: ALU result wins, otherwise drain the FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_en   <= 1'b0;
            r_rc     <= '0;
            r_dataC  <= '0;
            r_w_mode <= '0;
        end else if (alu_valid) begin
            r_w_en   <= (alu_rd != '0);
            r_rc     <= alu_rd;
            r_dataC  <= alu_data;
            r_w_mode <= W_MODE_WORD;
        end else if (w_pop) begin
            r_w_en   <= 1'b1;
            r_rc     <= w_head.rd;
            r_dataC  <= w_head.data;
            r_w_mode <= w_head.mode;
        end else begin
            r_w_en   <= 1'b0;
        end
    end

    // One-cycle pulse when an accepted load is dropped for misalignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept && w_mis;
        end
    end

    // Starvation counter: a head left waiting STARVE_LIM cycles forces an ALU bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve    <= '0;
            r_alu_stall <= 1'b0;
        end else if (w_empty || w_pop) begin
            r_starve    <= '0;
            r_alu_stall <= 1'b0;
        end else if (r_starve == STARVE_W'(STARVE_LIM - 1)) begin
            r_starve    <= '0;
            r_alu_stall <= 1'b1;
        end else begin
            r_starve    <= r_starve + STARVE_W'(1);
            r_alu_stall <= 1'b0;
        end
    end

    // Pending-write match against queued loads and the write stage.
    always_comb begin
        w_match_a = r_w_en && (r_rc == rs_a);
        w_match_b = r_w_en && (r_rc == rs_b);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_fifo_valid[i] && (w_fifo_rd[i] == rs_a)) begin
                w_match_a = 1'b1;
            end
            if (w_fifo_valid[i] && (w_fifo_rd[i] == rs_b)) begin
                w_match_b = 1'b1;
            end
        end
    end

    assign hazard_a  = (rs_a != '0) && w_match_a;
    assign hazard_b  = (rs_b != '0) && w_match_b;
    assign mem_ready = !w_full;
    assign misalign  = r_misalign;
    assign alu_stall = r_alu_stall;
    assign w_en      = r_w_en;
    assign rc        = r_rc;
    assign dataC     = r_dataC;
    assign w_mode    = r_w_mode;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the write-back rules.
module tb_reg_writeback;

    localparam int DEPTH      = 2;
    localparam int STARVE_LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        av, mv;
    logic [4:0]  ard, mrd, rs_a, rs_b;
    logic [31:0] adata, mdata;
    logic [1:0]  mmode, mlo;
    logic        alu_stall, mem_ready, misalign, hazard_a, hazard_b, w_en;
    logic [4:0]  rc;
    logic [31:0] dataC;
    logic [1:0]  w_mode;

    reg_writeback #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (av),
        .alu_rd      (ard),
        .alu_data    (adata),
        .alu_stall   (alu_stall),
        .mem_valid   (mv),
        .mem_ready   (mem_ready),
        .mem_rd      (mrd),
        .mem_data    (mdata),
        .mem_mode    (mmode),
        .mem_addr_lo (mlo),
        .misalign    (misalign),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .rc          (rc),
        .dataC       (dataC),
        .w_en        (w_en),
        .w_mode      (w_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rd;
        logic [31:0] data;
        int          mode;
    } ent_t;

    ent_t        q[$];
    int          m_en, m_rc, m_mode, m_stall, m_mis, m_sc, m_acc;
    logic [31:0] m_data;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_en = 0; m_rc = 0; m_data = '0; m_mode = 0;
        m_stall = 0; m_mis = 0; m_sc = 0; m_acc = 0;
    endfunction

    function automatic int bad_align(input int mode, input int lo);
        if (mode == 0) return (lo != 0) ? 1 : 0;
        if (mode == 1) return lo % 2;
        if (mode == 2) return 0;
        return 1;
    endfunction

    // One clock edge of the write-back rules, from the pre-edge state.
    function automatic void model_step();
        int   lo   = int'(mlo);
        int   mode = int'(mmode);
        int   rd   = int'(mrd);
        int   ready = (q.size() < DEPTH) ? 1 : 0;
        int   pop   = (q.size() > 0 && !av) ? 1 : 0;
        int   acc   = (mv && ready == 1) ? 1 : 0;
        int   mis   = bad_align(mode, lo);
        ent_t e;
        if (q.size() == 0 || pop == 1) begin
            m_sc = 0; m_stall = 0;
        end else begin
            m_sc++;
            m_stall = 0;
            if (m_sc == STARVE_LIM) begin m_stall = 1; m_sc = 0; end
        end
        if (av) begin
            m_en = (ard != 0) ? 1 : 0; m_rc = int'(ard); m_data = adata; m_mode = 0;
        end else if (pop == 1) begin
            m_en = 1; m_rc = q[0].rd; m_data = q[0].data; m_mode = q[0].mode;
        end else begin
            m_en = 0;
        end
        if (pop == 1) void'(q.pop_front());
        if (acc == 1 && mis == 0 && rd != 0) begin
            e.rd = rd; e.mode = mode;
            if (mode == 2)      e.data = mdata >> (lo * 8);
            else if (mode == 1) e.data = mdata >> ((lo / 2) * 16);
            else                e.data = mdata;
            q.push_back(e);
        end
        m_mis = (acc == 1 && mis == 1) ? 1 : 0;
        m_acc = acc;
    endfunction

    function automatic int exp_hz(input logic [4:0] rs);
        int r = int'(rs);
        if (r == 0) return 0;
        foreach (q[i]) if (q[i].rd == r) return 1;
        if (m_en == 1 && m_rc == r) return 1;
        return 0;
    endfunction

    task automatic compare();
        chk("w_en", 32'(w_en), 32'(m_en));
        if (m_en == 1) begin
            chk("rc", 32'(rc), 32'(m_rc));
            chk("dataC", dataC, m_data);
            chk("w_mode", 32'(w_mode), 32'(m_mode));
        end
        chk("alu_stall", 32'(alu_stall), 32'(m_stall));
        chk("misalign", 32'(misalign), 32'(m_mis));
        chk("mem_ready", 32'(mem_ready), (q.size() < DEPTH) ? 32'd1 : 32'd0);
        chk("hazard_a", 32'(hazard_a), 32'(exp_hz(rs_a)));
        chk("hazard_b", 32'(hazard_b), 32'(exp_hz(rs_b)));
    endtask

    // Upstream honours alu_stall; then one edge, model update, compare.
    task automatic cyc();
        if (m_stall == 1) av = 1'b0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        av = 0; ard = '0; adata = '0; mv = 0; mrd = '0; mdata = '0;
        mmode = '0; mlo = '0; rs_a = '0; rs_b = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_w_en"},   32'(w_en), 32'd0);
        chk({tag, "_rc"},     32'(rc), 32'd0);
        chk({tag, "_dataC"},  dataC, 32'd0);
        chk({tag, "_w_mode"}, 32'(w_mode), 32'd0);
        chk({tag, "_stall"},  32'(alu_stall), 32'd0);
        chk({tag, "_mis"},    32'(misalign), 32'd0);
        chk({tag, "_ready"},  32'(mem_ready), 32'd1);
    endtask

    int seen_rc[$];
    int k;

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU result appears one cycle later
        av = 1; ard = 5'd5; adata = 32'hDEADBEEF;
        cyc();
        chk("t1_rc", 32'(rc), 32'd5);
        chk("t1_data", dataC, 32'hDEADBEEF);
        av = 0;
        cyc();

        // Byte load at offset 2, written two cycles later
        mv = 1; mrd = 5'd7; mdata = 32'h11223344; mmode = 2'd2; mlo = 2'd2;
        cyc();
        mv = 0;
        cyc();
        chk("t2_en", 32'(w_en), 32'd1);
        chk("t2_rc", 32'(rc), 32'd7);
        chk("t2_byte", 32'(dataC[7:0]), 32'h22);
        chk("t2_mode", 32'(w_mode), 32'd2);
        cyc();

        // Loads behind busy ALU: fill, starve, stall bubble, in-order drain
        k = 0;
        seen_rc.delete();
        for (int c = 0; c < 22; c++) begin
            av = (c < 12) ? 1'b1 : 1'b0;
            ard = 5'(20 + c % 5); adata = $urandom;
            if (k < 3) begin
                mv = 1; mrd = 5'(10 + k); mdata = $urandom; mmode = 2'd0; mlo = 2'd0;
            end else begin
                mv = 0;
            end
            cyc();
            if (m_acc == 1) k++;
            if (w_en && rc >= 5'd10 && rc <= 5'd12) seen_rc.push_back(int'(rc));
        end
        chk("t3_nwrites", 32'(seen_rc.size()), 32'd3);
        for (int i = 0; i < seen_rc.size() && i < 3; i++)
            chk("t3_order", 32'(seen_rc[i]), 32'(10 + i));

        // Misaligned half load, then rd==0 ALU and load
        mv = 1; mrd = 5'd3; mdata = 32'hCAFEF00D; mmode = 2'd1; mlo = 2'd1;
        cyc();
        chk("t4_mis", 32'(misalign), 32'd1);
        mv = 0;
        cyc();
        chk("t4_nowrite", 32'(w_en), 32'd0);
        av = 1; ard = 5'd0; adata = 32'h12345678;
        mv = 1; mrd = 5'd0; mmode = 2'd0; mlo = 2'd0;
        cyc();
        chk("t4_rd0_alu", 32'(w_en), 32'd0);
        av = 0; mv = 0;
        cyc();
        chk("t4_rd0_load", 32'(w_en), 32'd0);

        // Hazard on a queued load until it retires
        rs_a = 5'd9; rs_b = 5'd1;
        av = 1; ard = 5'd1; adata = 32'h1;
        mv = 1; mrd = 5'd9; mdata = 32'hA5A5A5A5; mmode = 2'd0; mlo = 2'd0;
        cyc();
        mv = 0;
        for (int c = 0; c < 2; c++) begin av = 1; cyc(); end
        chk("t5_hz_busy", 32'(hazard_a), 32'd1);
        av = 0;
        cyc();
        chk("t5_hz_wr", 32'(hazard_a), 32'd1);
        cyc();
        chk("t5_hz_done", 32'(hazard_a), 32'd0);
        rs_a = 5'd0;
        mv = 1; mrd = 5'd9;
        cyc();
        mv = 0;
        chk("t5_rs0", 32'(hazard_a), 32'd0);
        cyc();
        cyc();

        // Reset with two loads queued
        av = 1; ard = 5'd2;
        for (int c = 0; c < 2; c++) begin
            mv = 1; mrd = 5'(14 + c); mdata = $urandom; mmode = 2'd0; mlo = 2'd0;
            av = 1;
            cyc();
        end
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        chk("t6_ready", 32'(mem_ready), 32'd1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            av    = ($urandom_range(0, 9) < 4);
            ard   = 5'($urandom_range(0, 15));
            adata = $urandom;
            mv    = ($urandom_range(0, 9) < 6);
            mrd   = 5'($urandom_range(0, 15));
            mdata = $urandom;
            mmode = 2'($urandom_range(0, 3));
            mlo   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            rs_a  = 5'($urandom_range(0, 15));
            rs_b  = 5'($urandom_range(0, 15));
            cyc();
        end
        idle_inputs();
        for (int c = 0; c < 6; c++) cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
